fetch_sequencer: RTL and testbench

Instruction-fetch and sequencing stage that sits directly upstream of the control unit. Holds the program counter, reads the instruction memory, and presents the latched opcode and literal to the decoder. Registers the ALU status flags and resolves jumps from the decoder's `is_jump`/`jump_cond` outputs. Each instruction takes a two-cycle FETCH/EXEC sequence.

---
 rtl/fetch_sequencer_if.sv | 30 +++
 rtl/fetch_sequencer.sv | 73 +++++++
 tb/tb_fetch_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory, decoder and status bus around the fetch stage
// slave  = fetch_sequencer side: drives im_addr, opcode, literal, instr_valid, flags, pc, halted
// master = environment side: drives stall, im_data, is_jump, jump_cond, flags_write, alu_flags
interface fetch_sequencer_if #(
  parameter int PC_W = 8,
  parameter int LIT_W = 8,
  parameter int OPC_W = 7
);
  logic stall;
  logic [PC_W-1:0] im_addr;
  logic [OPC_W+LIT_W-1:0] im_data;
  logic [OPC_W-1:0] opcode;
  logic [LIT_W-1:0] literal;
  logic instr_valid;
  logic is_jump;
  logic [3:0] jump_cond;
  logic flags_write;
  logic [3:0] alu_flags;
  logic [3:0] flags;
  logic [PC_W-1:0] pc;
  logic halted;
  modport master (
    output stall, im_data, is_jump, jump_cond, flags_write, alu_flags,
    input im_addr, opcode, literal, instr_valid, flags, pc, halted
  );
  modport slave (
    input stall, im_data, is_jump, jump_cond, flags_write, alu_flags,
    output im_addr, opcode, literal, instr_valid, flags, pc, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: two-cycle FETCH/EXEC instruction sequencer holding pc, IR and {Z,N,C,V} flags
// Ports: clk, reset (sync, active-high), bus (fetch_sequencer_if.slave).
// Optional HALT_ON_WRAP_EN: a non-jump EXEC at the last address halts instead of wrapping.
module fetch_sequencer #(
  parameter int PC_W = 8,
  parameter int LIT_W = 8,
  parameter int OPC_W = 7
) (
  input logic clk,
  input logic reset,
  fetch_sequencer_if.slave bus
);
`ifdef HALT_ON_WRAP_EN
  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
`else
  typedef enum logic [1:0] {FETCH, EXEC} state_t;
`endif
  state_t state, state_n;
  logic [PC_W-1:0] pc_q, pc_n;
  logic [OPC_W+LIT_W-1:0] ir_q, ir_n;
  logic [3:0] flags_q, flags_n;
  logic z, n, c, v, cond_ok, taken, do_fetch, do_exec, wrap_halt;
  assign {z, n, c, v} = flags_q;
  // conditions use the registered flags, so a write in this EXEC only affects the next instruction
  assign cond_ok = bus.jump_cond == 4'hf ? 1'b1 :
                   bus.jump_cond == 4'h1 ? z :
                   bus.jump_cond == 4'h2 ? !z :
                   bus.jump_cond == 4'h3 ? n :
                   bus.jump_cond == 4'h4 ? (!n && !z) :
                   bus.jump_cond == 4'h5 ? !n :
                   bus.jump_cond == 4'h6 ? (n || z) :
                   bus.jump_cond == 4'h7 ? c :
                   bus.jump_cond == 4'h8 ? v : 1'b0;
  assign do_fetch = state == FETCH && !bus.stall;
  assign do_exec = state == EXEC && !bus.stall;
  assign taken = bus.is_jump && cond_ok;
`ifdef HALT_ON_WRAP_EN
  assign wrap_halt = do_exec && !taken && &pc_q;
  assign bus.halted = state == HALT;
`else
  assign wrap_halt = 1'b0;
  assign bus.halted = 1'b0;
`endif
  always_comb begin
    pc_n = do_exec && !wrap_halt ? (taken ? ir_q[PC_W-1:0] : pc_q + PC_W'(1)) : pc_q;
    ir_n = do_fetch ? bus.im_data : ir_q;
    flags_n = do_exec && bus.flags_write ? bus.alu_flags : flags_q;
`ifdef HALT_ON_WRAP_EN
    state_n = bus.stall ? state : state == FETCH ? EXEC : state == EXEC ? (wrap_halt ? HALT : FETCH) : state;
`else
    state_n = bus.stall ? state : state == FETCH ? EXEC : FETCH;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc_q <= '0;
      ir_q <= '0;
      flags_q <= '0;
    end else begin
      state <= state_n;
      pc_q <= pc_n;
      ir_q <= ir_n;
      flags_q <= flags_n;
    end
  end
  assign bus.im_addr = pc_q;
  assign bus.pc = pc_q;
  assign bus.opcode = ir_q[OPC_W+LIT_W-1:LIT_W];
  assign bus.literal = ir_q[LIT_W-1:0];
  assign bus.flags = flags_q;
  assign bus.instr_valid = state == EXEC;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and randomized checks of fetch_sequencer against an instruction-level model
module tb_fetch_sequencer;
  localparam int PC_W = 8;
  localparam int LIT_W = 8;
  localparam int OPC_W = 7;
`ifdef HALT_ON_WRAP_EN
  localparam bit HOW = 1'b1;
`else
  localparam bit HOW = 1'b0;
`endif
  logic clk;
  logic reset;
  logic [OPC_W+LIT_W-1:0] imem [256];
  int n_cmp = 0;
  int n_bad = 0;
  int m_pc;
  bit m_exec, m_halt;
  logic [OPC_W+LIT_W-1:0] m_ir;
  logic [3:0] m_flags;
  fetch_sequencer_if #(.PC_W(PC_W), .LIT_W(LIT_W), .OPC_W(OPC_W)) bus ();
  fetch_sequencer #(.PC_W(PC_W), .LIT_W(LIT_W), .OPC_W(OPC_W)) dut (.clk(clk), .reset(reset), .bus(bus));
  assign bus.im_data = imem[bus.im_addr];
  always #5 clk = ~clk;
  function automatic bit cond_ok(input logic [3:0] code, input logic [3:0] f);
    bit fz, fn, fc, fv;
    {fz, fn, fc, fv} = f;
    case (code)
      4'hf: return 1'b1;
      4'h1: return fz;
      4'h2: return !fz;
      4'h3: return fn;
      4'h4: return !fn && !fz;
      4'h5: return !fn;
      4'h6: return fn || fz;
      4'h7: return fc;
      4'h8: return fv;
      default: return 1'b0;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one clock: apply inputs, advance the instruction-level model, then compare every output
  task automatic cyc(input bit rs, input bit st, input bit ij, input logic [3:0] jc, input bit fw, input logic [3:0] af);
    bit tk;
    reset = rs;
    bus.stall = st;
    bus.is_jump = ij;
    bus.jump_cond = jc;
    bus.flags_write = fw;
    bus.alu_flags = af;
    if (rs) begin
      m_pc = 0; m_exec = 0; m_halt = 0; m_ir = '0; m_flags = '0;
    end else if (!st && !m_halt) begin
      if (!m_exec) begin
        m_ir = imem[m_pc];
        m_exec = 1;
      end else begin
        tk = ij && cond_ok(jc, m_flags);
        if (fw) m_flags = af;
        m_exec = 0;
        if (tk) m_pc = int'(m_ir[PC_W-1:0]);
        else if (HOW && m_pc == 255) m_halt = 1;
        else m_pc = (m_pc + 1) % 256;
      end
    end
    @(posedge clk);
    #1;
    chk("pc", 32'(bus.pc), 32'(m_pc));
    chk("im_addr", 32'(bus.im_addr), 32'(m_pc));
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_exec));
    chk("flags", 32'(bus.flags), 32'(m_flags));
    chk("opcode", 32'(bus.opcode), 32'(m_ir[OPC_W+LIT_W-1:LIT_W]));
    chk("literal", 32'(bus.literal), 32'(m_ir[LIT_W-1:0]));
    chk("halted", 32'(bus.halted), 32'(m_halt));
  endtask
  task automatic nop;
    cyc(0, 0, 0, 4'h0, 0, 4'h0);
  endtask
  initial begin
    clk = 0;
    for (int i = 0; i < 256; i++) imem[i] = 15'($urandom);
    for (int i = 0; i < 4; i++) imem[i] = '0;
    imem[4] = {7'h11, 8'h00};
    imem[5] = {7'h22, 8'h20};
    imem[8'h20] = {7'h11, 8'h00};
    imem[8'h21] = {7'h22, 8'h20};
    imem[8'h22] = '0;
    imem[8'h23] = {7'h12, 8'h30};
    imem[8'h30] = {7'h33, 8'h40};
    imem[8'hff] = {7'h55, 8'h00};
    cyc(1, 0, 0, 4'h0, 0, 4'h0);
    cyc(1, 1, 1, 4'hf, 1, 4'hf);
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_flags", 32'(bus.flags), 32'h0);
    for (int i = 0; i < 6; i++) begin
      nop();
      chk("nop_pc", 32'(bus.pc), 32'((i + 1) / 2));
      chk("nop_valid", 32'(bus.instr_valid), 32'(i % 2 == 0));
    end
    nop(); nop();
    nop(); cyc(0, 0, 0, 4'h0, 1, 4'h8);
    chk("flags_z", 32'(bus.flags), 32'h8);
    nop(); cyc(0, 0, 1, 4'h1, 0, 4'h0);
    chk("jz_taken", 32'(bus.pc), 32'h20);
    nop(); cyc(0, 0, 0, 4'h0, 1, 4'h0);
    nop(); cyc(0, 0, 1, 4'h1, 0, 4'h0);
    chk("jz_not_taken", 32'(bus.pc), 32'h22);
    cyc(0, 0, 1, 4'hf, 1, 4'hf);
    chk("fetch_ign_pc", 32'(bus.pc), 32'h22);
    chk("fetch_ign_flags", 32'(bus.flags), 32'h0);
    nop();
    nop();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 4'hf, 1, 4'h4);
      chk("stall_pc", 32'(bus.pc), 32'h23);
      chk("stall_valid", 32'(bus.instr_valid), 32'h1);
      chk("stall_lit", 32'(bus.literal), 32'h30);
    end
    cyc(0, 0, 1, 4'hf, 1, 4'h4);
    chk("unstall_pc", 32'(bus.pc), 32'h30);
    chk("unstall_flags", 32'(bus.flags), 32'h4);
    nop(); cyc(1, 0, 1, 4'hf, 1, 4'hf);
    chk("rst_exec_pc", 32'(bus.pc), 32'h0);
    chk("rst_exec_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_exec_flags", 32'(bus.flags), 32'h0);
    imem[0] = {7'h44, 8'hff};
    nop(); cyc(0, 0, 1, 4'hf, 0, 4'h0);
    chk("jump_ff", 32'(bus.pc), 32'hff);
    nop(); nop();
`ifdef HALT_ON_WRAP_EN
    for (int i = 0; i < 3; i++) begin
      chk("halt_pc", 32'(bus.pc), 32'hff);
      chk("halt_flag", 32'(bus.halted), 32'h1);
      chk("halt_valid", 32'(bus.instr_valid), 32'h0);
      cyc(0, 0, 1, 4'hf, 1, 4'hf);
    end
`else
    chk("wrap_pc", 32'(bus.pc), 32'h0);
    chk("wrap_halted", 32'(bus.halted), 32'h0);
`endif
    cyc(1, 0, 0, 4'h0, 0, 4'h0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
